// File: rtl/riscv_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_trace_buffer_if
// Description : Readout stream of the trace buffer. The trace buffer drives
//               the entry fields and rd_valid/rd_last (master); the consumer
//               drives rd_ready (slave).
//   rd_valid    entry available          rd_ready    consumer accepts entry
//   rd_pc       entry PC                 rd_instr    entry instruction
//   rd_adr      entry ALU result/address rd_memwrite entry store flag
//   rd_last     final entry of the trace
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_trace_buffer_if #(
    parameter int XLEN = 32
);
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [XLEN-1:0] rd_adr;
    logic            rd_memwrite;
    logic            rd_last;

    modport master (
        output rd_valid, rd_pc, rd_instr, rd_adr, rd_memwrite, rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_pc, rd_instr, rd_adr, rd_memwrite, rd_last,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/riscv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_trace_buffer
// Description : On-chip trace capture for the RISC-V core. Records PC,
//               instruction, ALU result/address and MemWrite of each valid
//               capture sample into a circular buffer, stops a programmable
//               number of samples after a selectable trigger and streams the
//               held entries oldest-first over a valid/ready port.
// Ports       : clk, reset (async, active-low)
//               arm, trig_mode, trig_value, post_count   - capture control
//               cap_valid, cap_pc, cap_instr, cap_adr, cap_memwrite - taps
//               rd (riscv_trace_buffer_if.master)        - readout stream
//               rd_ts   (only with TRACE_TIMESTAMP_EN)   - entry timestamp
//               state, count                             - status
// Options     : TRACE_TIMESTAMP_EN adds a free-running cycle counter whose
//               value is stored per entry and presented on rd_ts.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 16
`endif
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             arm,
    input  wire logic [1:0]       trig_mode,
    input  wire logic [XLEN-1:0]  trig_value,
    input  wire logic [CNT_W-1:0] post_count,
    input  wire logic             cap_valid,
    input  wire logic [XLEN-1:0]  cap_pc,
    input  wire logic [31:0]      cap_instr,
    input  wire logic [XLEN-1:0]  cap_adr,
    input  wire logic             cap_memwrite,
    riscv_trace_buffer_if.master  rd,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]       rd_ts,
`endif
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, rd_cnt, remaining, post_q;
    logic [1:0]       mode_q;
    logic [XLEN-1:0]  value_q;

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [31:0]      mem_instr [DEPTH];
    logic [XLEN-1:0]  mem_adr   [DEPTH];
    logic             mem_mw    [DEPTH];

    logic             hit, do_arm, do_write, load_rem, dec_rem, go_done, do_pop, go_idle;
    logic [CNT_W-1:0] count_inc;
    logic [PTR_W-1:0] wr_ptr_inc;

    // Saturating count: once full, each new write overwrites the oldest entry.
    assign count_inc  = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
    assign wr_ptr_inc = wr_ptr + 1'b1;

    always_comb begin
        hit = 1'b0;
        case (mode_q)
            2'd0:    hit = cap_valid;
            2'd1:    hit = cap_valid && (cap_pc == value_q);
            2'd2:    hit = cap_valid && cap_memwrite;
            default: hit = cap_valid && cap_memwrite && (cap_adr == value_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_arm   = 1'b0;
        do_write = 1'b0;
        load_rem = 1'b0;
        dec_rem  = 1'b0;
        go_done  = 1'b0;
        do_pop   = 1'b0;
        go_idle  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    do_arm  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cap_valid) begin
                    do_write = 1'b1;
                    if (hit) begin
                        if (post_q == '0) begin
                            go_done = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            load_rem = 1'b1;
                            state_d  = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (cap_valid) begin
                    do_write = 1'b1;
                    dec_rem  = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        go_done = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                // Re-arm takes priority over a handshake in the same cycle.
                if (arm) begin
                    do_arm  = 1'b1;
                    state_d = S_ARMED;
                end else if (rd.rd_ready) begin
                    do_pop = 1'b1;
                    if (rd_cnt == CNT_W'(1)) begin
                        go_idle = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rd_cnt    <= '0;
            remaining <= '0;
            post_q    <= '0;
            mode_q    <= '0;
            value_q   <= '0;
        end else begin
            if (do_arm) begin
                wr_ptr  <= '0;
                count_q <= '0;
                mode_q  <= trig_mode;
                value_q <= trig_value;
                post_q  <= (post_count > POST_MAX) ? POST_MAX : post_count;
            end
            if (do_write) begin
                wr_ptr  <= wr_ptr_inc;
                count_q <= count_inc;
            end
            if (load_rem) remaining <= post_q;
            if (dec_rem)  remaining <= remaining - 1'b1;
            // go_done always coincides with the final write, so the post-write
            // count/pointer decide where the oldest entry sits.
            if (go_done) begin
                rd_ptr <= (count_inc == DEPTH_C) ? wr_ptr_inc : '0;
                rd_cnt <= count_inc;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (go_idle) count_q <= '0;
        end
    end

    // Entry storage carries no reset; contents are only read in DONE.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_pc[wr_ptr]    <= cap_pc;
            mem_instr[wr_ptr] <= cap_instr;
            mem_adr[wr_ptr]   <= cap_adr;
            mem_mw[wr_ptr]    <= cap_memwrite;
        end
    end

    assign rd.rd_valid    = (state_q == S_DONE);
    assign rd.rd_pc       = rd.rd_valid ? mem_pc[rd_ptr]    : '0;
    assign rd.rd_instr    = rd.rd_valid ? mem_instr[rd_ptr] : '0;
    assign rd.rd_adr      = rd.rd_valid ? mem_adr[rd_ptr]   : '0;
    assign rd.rd_memwrite = rd.rd_valid && mem_mw[rd_ptr];
    assign rd.rd_last     = rd.rd_valid && (rd_cnt == CNT_W'(1));
    assign state          = state_q;
    assign count          = count_q;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_ts[wr_ptr] <= ts_q;
    end

    assign rd_ts = rd.rd_valid ? mem_ts[rd_ptr] : '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_riscv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_trace_buffer
// Description : Self-checking bench for riscv_trace_buffer. A queue-based
//               model of the trace (capture history, trigger rules, oldest-
//               first readout) is compared against the DUT every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             arm = 1'b0;
    logic [1:0]       trig_mode = '0;
    logic [XLEN-1:0]  trig_value = '0;
    logic [CNT_W-1:0] post_count = '0;
    logic             cap_valid = 1'b0;
    logic [XLEN-1:0]  cap_pc = '0;
    logic [31:0]      cap_instr = '0;
    logic [XLEN-1:0]  cap_adr = '0;
    logic             cap_memwrite = 1'b0;
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]      rd_ts;
`endif

    riscv_trace_buffer_if #(.XLEN(XLEN)) rif ();

    riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode),
        .trig_value(trig_value), .post_count(post_count), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_adr(cap_adr),
        .cap_memwrite(cap_memwrite), .rd(rif.master),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .state(state), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] adr;
        logic        mw;
        logic [15:0] ts;
    } ent_t;

    ent_t        q[$];
    int          m_state = 0;   // 0 IDLE, 1 ARMED, 2 POST, 3 DONE
    int          m_post = 0, m_rem = 0, m_ri = 0;
    logic [1:0]  m_mode = '0;
    logic [31:0] m_val = '0;
    int          m_ts = 0;

    function automatic bit trig_hit(input logic [31:0] pc, input logic [31:0] adr, input logic mw);
        case (m_mode)
            2'd0:    return 1'b1;
            2'd1:    return pc == m_val;
            2'd2:    return mw;
            default: return mw && (adr == m_val);
        endcase
    endfunction

    task automatic m_record();
        ent_t e;
        e.pc = cap_pc; e.instr = cap_instr; e.adr = cap_adr; e.mw = cap_memwrite;
        e.ts = m_ts[15:0];
        q.push_back(e);
        if (q.size() > DEPTH) void'(q.pop_front());
    endtask

    task automatic m_arm();
        q.delete();
        m_mode  = trig_mode;
        m_val   = trig_value;
        m_post  = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
        m_state = 1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_state = 0;
            m_ts    = 0;
        end else begin
            case (m_state)
                0: if (arm) m_arm();
                1: if (cap_valid) begin
                    m_record();
                    if (trig_hit(cap_pc, cap_adr, cap_memwrite)) begin
                        if (m_post == 0) begin m_state = 3; m_ri = 0; end
                        else begin m_state = 2; m_rem = m_post; end
                    end
                end
                2: if (cap_valid) begin
                    m_record();
                    m_rem--;
                    if (m_rem == 0) begin m_state = 3; m_ri = 0; end
                end
                default: begin
                    if (arm) m_arm();
                    else if (rif.rd_ready) begin
                        if (m_ri == q.size() - 1) begin m_state = 0; q.delete(); end
                        else m_ri++;
                    end
                end
            endcase
            m_ts++;
        end
    end

    // Per-cycle comparison, half a period away from the sampling edge.
    always @(negedge clk) begin
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(q.size()));
        chk("rd_valid", 64'(rif.rd_valid), 64'(m_state == 3));
        if (m_state == 3 && m_ri < q.size()) begin
            chk("rd_pc", 64'(rif.rd_pc), 64'(q[m_ri].pc));
            chk("rd_instr", 64'(rif.rd_instr), 64'(q[m_ri].instr));
            chk("rd_adr", 64'(rif.rd_adr), 64'(q[m_ri].adr));
            chk("rd_memwrite", 64'(rif.rd_memwrite), 64'(q[m_ri].mw));
            chk("rd_last", 64'(rif.rd_last), 64'(m_ri == q.size() - 1));
`ifdef TRACE_TIMESTAMP_EN
            chk("rd_ts", 64'(rd_ts), 64'(q[m_ri].ts));
`endif
        end else begin
            chk("rd_last_idle", 64'(rif.rd_last), 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] got_pc[$];
    logic [31:0] got_adr[$];
    logic        got_mw[$];
    logic        got_last[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [31:0] val, input logic [CNT_W-1:0] post);
        trig_mode = mode; trig_value = val; post_count = post; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] adr, input logic mw);
        cap_valid = 1'b1; cap_pc = pc; cap_instr = {pc[23:0], 8'h13};
        cap_adr = adr; cap_memwrite = mw;
        tick();
        cap_valid = 1'b0; cap_memwrite = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        got_pc.delete(); got_adr.delete(); got_mw.delete(); got_last.delete();
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (rif.rd_valid) begin
                got_pc.push_back(rif.rd_pc);
                got_adr.push_back(rif.rd_adr);
                got_mw.push_back(rif.rd_memwrite);
                got_last.push_back(rif.rd_last);
                done = rif.rd_last;
            end
            tick();
        end
        rif.rd_ready = 1'b0;
        chk("drain_done", 64'(done), 64'd1);
    endtask

    logic [31:0] held[4];
    int          nlast;

    initial begin
        rif.rd_ready = 1'b0;
        tick(); tick();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rd_valid", 64'(rif.rd_valid), 64'd0);
        reset = 1'b1;
        tick();

        // 1: reset mid-POST, then rearm
        do_arm(2'd0, 32'h0, 5'd5);
        cap(32'h0, 32'h100, 1'b0);
        cap(32'h4, 32'h104, 1'b0);
        chk("t1_in_post", 64'(state), 64'd2);
        reset = 1'b0;
        #1;
        chk("t1_async_state", 64'(state), 64'd0);
        chk("t1_async_count", 64'(count), 64'd0);
        chk("t1_async_valid", 64'(rif.rd_valid), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        do_arm(2'd0, 32'h0, 5'd1);
        cap(32'h40, 32'h140, 1'b0);
        cap(32'h44, 32'h144, 1'b0);
        chk("t1_rearm_count", 64'(count), 64'd2);
        drain();
        chk("t1_rearm_first", 64'(got_pc[0]), 64'h40);

        // 2: PC trigger, no wrap
        do_arm(2'd1, 32'h0000000C, 5'd2);
        for (int i = 0; i < 6; i++) cap(32'(4 * i), 32'(32'h100 + 4 * i), 1'b0);
        chk("t2_state", 64'(state), 64'd3);
        chk("t2_count", 64'(count), 64'd6);
        drain();
        chk("t2_n", 64'(got_pc.size()), 64'd6);
        nlast = 0;
        foreach (got_pc[i]) begin
            chk("t2_pc", 64'(got_pc[i]), 64'(4 * i));
            if (got_last[i]) nlast++;
        end
        chk("t2_nlast", 64'(nlast), 64'd1);
        chk("t2_idle", 64'(state), 64'd0);

        // 3: wrap-around
        do_arm(2'd1, 32'h50, 5'd3);
        for (int i = 0; i < 24; i++) cap(32'(4 * i), 32'(32'h100 + 4 * i), 1'b0);
        chk("t3_count", 64'(count), 64'd16);
        drain();
        chk("t3_n", 64'(got_pc.size()), 64'd16);
        foreach (got_pc[i]) chk("t3_pc", 64'(got_pc[i]), 64'(32'h20 + 4 * i));

        // 4: first-MemWrite trigger, post 0
        do_arm(2'd2, 32'h0, 5'd0);
        for (int i = 0; i < 6; i++)
            cap(32'(32'h300 + 4 * i), (i == 5) ? 32'h64 : 32'(32'h100 + 4 * i), i == 5);
        chk("t4_state", 64'(state), 64'd3);
        chk("t4_count", 64'(count), 64'd6);
        drain();
        chk("t4_last_mw", 64'(got_mw[5]), 64'd1);
        chk("t4_last_adr", 64'(got_adr[5]), 64'h64);
        chk("t4_first_mw", 64'(got_mw[0]), 64'd0);

        // 4b: MemWrite with matching address
        do_arm(2'd3, 32'h64, 5'd1);
        cap(32'h500, 32'h60, 1'b1);
        cap(32'h504, 32'h64, 1'b0);
        cap(32'h508, 32'h64, 1'b1);
        chk("t4b_post", 64'(state), 64'd2);
        cap(32'h50C, 32'h68, 1'b0);
        chk("t4b_count", 64'(count), 64'd4);
        drain();

        // 5: gaps and post clamp (31 -> 15)
        do_arm(2'd0, 32'h0, 5'd31);
        for (int i = 0; i < 16; i++) begin
            cap(32'(32'h600 + 4 * i), 32'(32'h700 + 4 * i), 1'b0);
            if (i == 14) chk("t5_still_post", 64'(state), 64'd2);
            tick();  // idle sample: no write, no decrement
        end
        chk("t5_state", 64'(state), 64'd3);
        chk("t5_count", 64'(count), 64'd16);
        drain();
        chk("t5_first", 64'(got_pc[0]), 64'h600);
        chk("t5_last", 64'(got_pc[15]), 64'h63C);

        // 6: backpressure and re-arm during DONE
        do_arm(2'd0, 32'h0, 5'd3);
        for (int i = 0; i < 4; i++) cap(32'(32'h200 + 4 * i), 32'h0, 1'b0);
        chk("t6_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            rif.rd_ready = (i == 0 || i == 3);
            held[i] = rif.rd_pc;
            tick();
        end
        rif.rd_ready = 1'b0;
        chk("t6_pc0", 64'(held[0]), 64'h200);
        chk("t6_pc1", 64'(held[1]), 64'h204);
        chk("t6_pc2", 64'(held[2]), 64'h204);
        chk("t6_pc3", 64'(held[3]), 64'h204);
        do_arm(2'd0, 32'h0, 5'd1);
        chk("t6_rearm_state", 64'(state), 64'd1);
        chk("t6_rearm_count", 64'(count), 64'd0);
        chk("t6_rearm_valid", 64'(rif.rd_valid), 64'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Synthesizable on-chip trace capture unit for the RISC-V core; replaces per-cycle simulation printouts with a hardware record.
- Records PC, instruction, ALU result/data address and MemWrite per committed cycle into a circular buffer.
- Supports a selectable trigger and programmable post-trigger depth, then streams entries oldest-first over a valid/ready port.
- Sits beside the core, fed from fetch/datapath taps.

Parameters:
XLEN, 32, width of PC, instruction and address fields
DEPTH, 16, buffer entries; power of two, >= 4
CNT_W, $clog2(DEPTH)+1, width of count/post_count fields

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
arm  in  1  single-cycle pulse; starts a new capture
trig_mode  in  2  0 immediate, 1 PC == trig_value, 2 first MemWrite, 3 MemWrite with adr == trig_value
trig_value  in  XLEN  compare value for modes 1/3
post_count  in  CNT_W  captures recorded after the trigger entry; sampled on arm; clamped to DEPTH-1
cap_valid  in  1  capture sample valid this cycle
cap_pc  in  XLEN  PC
cap_instr  in  32  instruction
cap_adr  in  XLEN  ALU result / data address
cap_memwrite  in  1  store flag
rd_valid  out  1  entry available
rd_ready  in  1  consumer accepts entry
rd_pc  out  XLEN  entry PC
rd_instr  out  32  entry instruction
rd_adr  out  XLEN  entry address
rd_memwrite  out  1  entry store flag
rd_last  out  1  final entry of this trace
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  out  CNT_W  valid entries held (0..DEPTH)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; count, write/read pointers, remaining and all rd_* outputs = 0. Buffer contents need not be cleared. Reset during any state aborts it immediately.
- IDLE: captures ignored. arm=1 -> ARMED next edge; clears wr_ptr and count; latches trig_mode, trig_value and min(post_count, DEPTH-1).
- ARMED: each cap_valid=1 cycle writes the entry at wr_ptr. wr_ptr increments modulo DEPTH; count saturates at DEPTH (oldest overwritten).
- Trigger is evaluated on the same sample. Mode 0 fires on the first cap_valid.
  - Trigger with latched post=0 -> DONE.
  - Otherwise -> POST with remaining=post.
- POST: each cap_valid writes an entry and decrements remaining. The write that takes remaining 1->0 moves to DONE. cap_valid=0 cycles neither write nor decrement.
- DONE: captures ignored.
  - rd_valid=1 from the first DONE cycle.
  - rd_ptr starts at wr_ptr if count==DEPTH, else 0.
  - rd_* reflect mem[rd_ptr] combinationally and hold stable while rd_valid && !rd_ready.
  - Handshake (rd_valid && rd_ready) advances rd_ptr modulo DEPTH and decrements an internal read counter initialised to count.
  - rd_last=1 when read counter == 1. Handshake on rd_last -> IDLE, rd_valid=0.
- arm in ARMED/POST is ignored. arm in DONE aborts readout and re-arms (ARMED, count=0). arm coincident with the last handshake: arm wins.
- count output holds its final value through DONE and returns to 0 on entering IDLE.
- Compares are full XLEN equality. No partial-word masking.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- When defined: adds parameter TS_W (default 16) and output rd_ts [TS_W-1:0].
  - A free-running cycle counter, reset to 0, increments every clk and wraps at 2^TS_W.
  - Its value is stored with each written entry and presented on rd_ts alongside the other rd_* fields.
- When undefined: no counter, no rd_ts port, entry width unchanged; all other behaviour identical.

Test Plan:
1. Reset mid-POST: drive reset=0 for one cycle during POST -> state=0, count=0, rd_valid=0 immediately (before the next edge); rearming afterwards works normally.
2. PC trigger, no wrap: trig_mode=1, trig_value=0x0000000C, post_count=2, PCs 0x0,0x4,... one per cycle -> DONE after PC 0x14. count=6. Readout PCs 0x0..0x14 in order, rd_last only on 0x14, then state=0.
3. Wrap-around: trig_mode=1, trig_value=0x50, post_count=3 -> count=16. Readout starts at PC 0x20 and ends at 0x5C with rd_last. No entry is duplicated.
4. MemWrite trigger: trig_mode=2, post_count=0, cap_memwrite=1 only on the 6th capture (adr 0x64) -> DONE immediately, count=6. Last entry has rd_memwrite=1, rd_adr=0x64.
5. Gaps and clamp: post_count=31 with DEPTH=16 -> exactly 15 post entries after the trigger. cap_valid=0 cycles interleaved -> no writes, no decrement.
6. Backpressure and re-arm: rd_ready toggled 1,0,0,1 -> rd_* stable while stalled. arm during DONE -> state=1, count=0, rd_valid=0 next cycle.
